// File: rtl/cvspangen_if.sv
// Span descriptor handshake plus the per-pixel output stream of the cv span walker.
// The master side issues descriptors and consumes pixels; the walker is the slave.
interface cvspangen_if #(
    parameter int XW = 12
);
    logic          span_req;
    logic          span_rdy;
    logic [XW-1:0] span_xs;
    logic [XW-1:0] span_xe;
    logic          span_lft;
    logic [XW-1:0] clip_xmin;
    logic [XW-1:0] clip_xmax;
    logic          stall;
    logic          new_span;
    logic          valid_pixel_m;
    logic [XW-1:0] pix_x;
    logic          span_done;

    modport slave (
        input  span_req, span_xs, span_xe, span_lft, clip_xmin, clip_xmax, stall,
        output span_rdy, new_span, valid_pixel_m, pix_x, span_done
    );

    modport master (
        output span_req, span_xs, span_xe, span_lft, clip_xmin, clip_xmax, stall,
        input  span_rdy, new_span, valid_pixel_m, pix_x, span_done
    );
endinterface

// File: rtl/cvspangen.sv
// Span walker: latches one span descriptor, emits a new_span marker, then one
// pixel per unstalled clock flagged valid when x lies inside the clip window.
module cvspangen #(
    parameter int XW = 12
) (
    input  logic        gclk,
    input  logic        reset,
    cvspangen_if.slave  bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_WALK} state_t;

    state_t        state_q, state_d;
    logic [XW-1:0] xe_q, xe_d;
    logic          lft_q, lft_d;
    logic [XW-1:0] cmin_q, cmin_d;
    logic [XW-1:0] cmax_q, cmax_d;
    logic          new_span_q, new_span_d;
    logic          valid_q, valid_d;
    logic [XW-1:0] pix_x_q, pix_x_d;
    logic          done_q, done_d;
    logic          rdy;
    logic          take;
    logic          at_last;
    logic [XW-1:0] x_next;

    function automatic logic in_clip(input logic [XW-1:0] x,
                                     input logic [XW-1:0] lo,
                                     input logic [XW-1:0] hi);
        return (lo <= x) && (x <= hi);
    endfunction

    always_ff @(posedge gclk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            xe_q       <= '0;
            lft_q      <= 1'b0;
            cmin_q     <= '0;
            cmax_q     <= '0;
            new_span_q <= 1'b0;
            valid_q    <= 1'b0;
            pix_x_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            xe_q       <= xe_d;
            lft_q      <= lft_d;
            cmin_q     <= cmin_d;
            cmax_q     <= cmax_d;
            new_span_q <= new_span_d;
            valid_q    <= valid_d;
            pix_x_q    <= pix_x_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        xe_d       = xe_q;
        lft_d      = lft_q;
        cmin_d     = cmin_q;
        cmax_d     = cmax_q;
        new_span_d = new_span_q;
        valid_d    = valid_q;
        pix_x_d    = pix_x_q;
        done_d     = done_q;
        rdy        = 1'b0;
        take       = 1'b0;
        at_last    = (pix_x_q == xe_q);
        x_next     = lft_q ? (pix_x_q + 1'b1) : (pix_x_q - 1'b1);

        unique case (state_q)
            ST_IDLE: begin
                rdy        = 1'b1;
                take       = bus.span_req;
                new_span_d = 1'b0;
                valid_d    = 1'b0;
                done_d     = 1'b0;
            end
            ST_START: begin
                // done_q is only set in START for an inconsistent span
                new_span_d = 1'b0;
                if (done_q) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    done_d  = 1'b0;
                end else begin
                    state_d = ST_WALK;
                    valid_d = in_clip(pix_x_q, cmin_q, cmax_q);
                    done_d  = at_last;
                end
            end
            ST_WALK: begin
                if (!bus.stall) begin
                    if (!at_last) begin
                        pix_x_d = x_next;
                        valid_d = in_clip(x_next, cmin_q, cmax_q);
                        done_d  = (x_next == xe_q);
                    end else begin
                        rdy     = 1'b1;
                        take    = bus.span_req;
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                        done_d  = 1'b0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (take) begin
            state_d    = ST_START;
            xe_d       = bus.span_xe;
            lft_d      = bus.span_lft;
            cmin_d     = bus.clip_xmin;
            cmax_d     = bus.clip_xmax;
            pix_x_d    = bus.span_xs;
            new_span_d = 1'b1;
            valid_d    = 1'b0;
            done_d     = bus.span_lft ? (bus.span_xe < bus.span_xs)
                                      : (bus.span_xe > bus.span_xs);
        end
    end

    assign bus.span_rdy      = rdy;
    assign bus.new_span      = new_span_q;
    assign bus.valid_pixel_m = valid_q;
    assign bus.pix_x         = pix_x_q;
    assign bus.span_done     = done_q;
endmodule

// File: tb/tb_cvspangen.sv
// Directed bench for the cv span walker: walks, clipping, reverse, stall,
// back-to-back spans and asynchronous reset mid-span.
module tb_cvspangen;
    localparam int XW = 12;

    logic gclk;
    logic reset;
    int   total_cnt;
    int   pass_cnt;

    cvspangen_if #(.XW(XW)) bif ();

    cvspangen #(.XW(XW)) dut (
        .gclk  (gclk),
        .reset (reset),
        .bus   (bif)
    );

    initial begin
        gclk = 1'b0;
        forever #5 gclk = ~gclk;
    end

    task automatic tick();
        @(posedge gclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // px < 0 means pix_x is not checked on this cycle
    task automatic exp_out(input string tag, input logic ns, input logic vp,
                           input int px, input logic dn, input logic rdy);
        chk({tag, ".new_span"}, {31'b0, bif.new_span}, {31'b0, ns});
        chk({tag, ".valid"},    {31'b0, bif.valid_pixel_m}, {31'b0, vp});
        if (px >= 0)
            chk({tag, ".pix_x"}, {20'b0, bif.pix_x}, px);
        chk({tag, ".done"},     {31'b0, bif.span_done}, {31'b0, dn});
        chk({tag, ".rdy"},      {31'b0, bif.span_rdy}, {31'b0, rdy});
    endtask

    task automatic set_span(input int xs, input int xe, input logic lft,
                            input int cmin, input int cmax);
        bif.span_xs   = xs[XW-1:0];
        bif.span_xe   = xe[XW-1:0];
        bif.span_lft  = lft;
        bif.clip_xmin = cmin[XW-1:0];
        bif.clip_xmax = cmax[XW-1:0];
    endtask

    initial begin
        logic [7:0] clip_exp;
        total_cnt = 0;
        pass_cnt  = 0;
        clip_exp  = 8'b0011_1000;   // bit i = expected valid of pixel i (x = 5+i)
        reset        = 1'b0;
        bif.span_req = 1'b0;
        bif.stall    = 1'b0;
        set_span(0, 0, 1'b1, 0, 4095);

        #1;
        exp_out("reset", 1'b0, 1'b0, 0, 1'b0, 1'b1);
        tick();
        tick();
        reset = 1'b1;
        exp_out("post_reset", 1'b0, 1'b0, 0, 1'b0, 1'b1);

        // Basic walk 10..13
        set_span(10, 13, 1'b1, 0, 4095);
        bif.span_req = 1'b1;
        tick();
        bif.span_req = 1'b0;
        set_span(99, 0, 1'b0, 0, 0);   // descriptor must already be latched
        exp_out("basic.start", 1'b1, 1'b0, 10, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_out($sformatf("basic.pix%0d", i), 1'b0, 1'b1, 10 + i, (i == 3), (i == 3));
        end
        tick();
        exp_out("basic.idle", 1'b0, 1'b0, -1, 1'b0, 1'b1);
        $display("span basic 10..13 complete");

        // Clipping 5..12 with window 8..10
        set_span(5, 12, 1'b1, 8, 10);
        bif.span_req = 1'b1;
        tick();
        bif.span_req = 1'b0;
        exp_out("clip.start", 1'b1, 1'b0, 5, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick();
            exp_out($sformatf("clip.pix%0d", i), 1'b0, clip_exp[i], 5 + i, (i == 7), (i == 7));
        end
        tick();
        exp_out("clip.idle", 1'b0, 1'b0, -1, 1'b0, 1'b1);
        $display("span clip 5..12 window 8..10 complete");

        // Reverse walk 20..17
        set_span(20, 17, 1'b0, 0, 4095);
        bif.span_req = 1'b1;
        tick();
        bif.span_req = 1'b0;
        exp_out("rev.start", 1'b1, 1'b0, 20, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_out($sformatf("rev.pix%0d", i), 1'b0, 1'b1, 20 - i, (i == 3), (i == 3));
        end
        tick();
        exp_out("rev.idle", 1'b0, 1'b0, -1, 1'b0, 1'b1);
        $display("span reverse 20..17 complete");

        // Inconsistent descriptor 17..20 walking left
        set_span(17, 20, 1'b0, 0, 4095);
        bif.span_req = 1'b1;
        tick();
        bif.span_req = 1'b0;
        exp_out("bad.start", 1'b1, 1'b0, 17, 1'b1, 1'b0);
        tick();
        exp_out("bad.idle", 1'b0, 1'b0, -1, 1'b0, 1'b1);
        $display("span inconsistent 17..20 dropped");

        // Stall two cycles on pixel 11
        set_span(10, 13, 1'b1, 0, 4095);
        bif.span_req = 1'b1;
        tick();
        bif.span_req = 1'b0;
        exp_out("stall.start", 1'b1, 1'b0, 10, 1'b0, 1'b0);
        tick();
        exp_out("stall.pix10", 1'b0, 1'b1, 10, 1'b0, 1'b0);
        tick();
        bif.stall = 1'b1;
        exp_out("stall.pix11a", 1'b0, 1'b1, 11, 1'b0, 1'b0);
        tick();
        exp_out("stall.pix11b", 1'b0, 1'b1, 11, 1'b0, 1'b0);
        tick();
        bif.stall = 1'b0;
        exp_out("stall.pix11c", 1'b0, 1'b1, 11, 1'b0, 1'b0);
        tick();
        exp_out("stall.pix12", 1'b0, 1'b1, 12, 1'b0, 1'b0);
        tick();
        exp_out("stall.pix13", 1'b0, 1'b1, 13, 1'b1, 1'b1);
        tick();
        exp_out("stall.idle", 1'b0, 1'b0, -1, 1'b0, 1'b1);
        $display("span stall 10..13 complete");

        // Back-to-back: A = 3..4, B = 7..7, span_req held
        set_span(3, 4, 1'b1, 0, 4095);
        bif.span_req = 1'b1;
        tick();
        set_span(7, 7, 1'b1, 0, 4095);
        exp_out("b2b.startA", 1'b1, 1'b0, 3, 1'b0, 1'b0);
        tick();
        exp_out("b2b.pix3", 1'b0, 1'b1, 3, 1'b0, 1'b0);
        tick();
        exp_out("b2b.pix4", 1'b0, 1'b1, 4, 1'b1, 1'b1);
        tick();
        bif.span_req = 1'b0;
        exp_out("b2b.startB", 1'b1, 1'b0, 7, 1'b0, 1'b0);
        tick();
        exp_out("b2b.pix7", 1'b0, 1'b1, 7, 1'b1, 1'b1);
        tick();
        exp_out("b2b.idle", 1'b0, 1'b0, -1, 1'b0, 1'b1);
        $display("span back-to-back 3..4 / 7 complete");

        // Asynchronous reset at pixel 12
        set_span(10, 13, 1'b1, 0, 4095);
        bif.span_req = 1'b1;
        tick();
        bif.span_req = 1'b0;
        tick();
        tick();
        tick();
        exp_out("rst.pix12", 1'b0, 1'b1, 12, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        exp_out("rst.async", 1'b0, 1'b0, 0, 1'b0, 1'b1);
        tick();
        exp_out("rst.held", 1'b0, 1'b0, 0, 1'b0, 1'b1);
        #2;
        reset = 1'b1;
        tick();
        exp_out("rst.rel1", 1'b0, 1'b0, 0, 1'b0, 1'b1);
        tick();
        exp_out("rst.rel2", 1'b0, 1'b0, 0, 1'b0, 1'b1);
        $display("span reset mid-walk discarded");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
